// File: rtl/hack_soc_pkg.sv
// Shared types and helpers for the hack_soc stream demux.
// Holds the channel index type, the channel-count ceiling and the select legality test.
package hack_soc_pkg;

  localparam int DMUX_MAX_OUT = 16;

  typedef logic [$clog2(DMUX_MAX_OUT)-1:0] chan_idx_t;

  function automatic logic sel_legal(input int unsigned sel, input int unsigned n);
    return sel < n;
  endfunction

endpackage

// File: rtl/dmux_stream_slot.sv
// One-entry holding register for a single demux output channel.
// A load is taken only when the slot is free, so a stalled payload never changes.
module dmux_stream_slot #(
  parameter int D_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [D_WIDTH-1:0] din,
  input  logic               ready,
  output logic               valid,
  output logic [D_WIDTH-1:0] dout
);

  logic               slot_v;
  logic [D_WIDTH-1:0] slot_d;
  logic               free;
  logic               load;
  logic               pop;

  assign free = !slot_v || ready;
  assign load = push && free;
  assign pop  = slot_v && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_v <= 1'b0;
      slot_d <= '0;
    end else if (load) begin
      slot_v <= 1'b1;
      slot_d <= din;
    end else if (pop) begin
      slot_v <= 1'b0;
      slot_d <= '0;
    end
  end

  assign valid = slot_v;
  // Idle channels read zero, like the unselected outputs of the old combinational demux.
  assign dout  = slot_v ? slot_d : '0;

endmodule

// File: rtl/dmux_stream_nway.sv
// Registered 1-to-N stream demux with per-channel one-entry slots and a sticky bad_sel flag.
// Optional broadcast mode (input in_bcast) is built when DMUX_STREAM_BROADCAST_EN is defined.
module dmux_stream_nway
  import hack_soc_pkg::*;
#(
  parameter int D_WIDTH   = 16,
  parameter int N_OUT     = 8,
  parameter int SEL_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [D_WIDTH-1:0]       in_data,
  input  logic [SEL_WIDTH-1:0]     in_sel,
`ifdef DMUX_STREAM_BROADCAST_EN
  input  logic                     in_bcast,
`endif
  output logic [N_OUT-1:0]         out_valid,
  input  logic [N_OUT-1:0]         out_ready,
  output logic [N_OUT*D_WIDTH-1:0] out_data,
  output logic                     bad_sel,
  input  logic                     bad_sel_clr
);

  if ((2**SEL_WIDTH) < N_OUT || N_OUT < 2 || N_OUT > DMUX_MAX_OUT) begin : g_param_check
    $error("dmux_stream_nway: illegal N_OUT/SEL_WIDTH combination");
  end

  // Handshake: a beat transfers on a rising edge where in_valid && in_ready; each channel k
  // hands off its slot on an edge where out_valid[k] && out_ready[k]. in_ready never waits
  // on in_valid, and out_valid[k] never waits on out_ready[k].
  logic            bcast;
  logic            sel_ok;
  chan_idx_t       sel_idx;
  logic [N_OUT-1:0] free;
  logic [N_OUT-1:0] push;
  logic            free_sel;
  logic            accept;
  logic            bad_set;

`ifdef DMUX_STREAM_BROADCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif

  assign sel_ok  = sel_legal(32'(in_sel), N_OUT);
  assign sel_idx = chan_idx_t'(in_sel);
  assign free    = ~out_valid | out_ready;

  always_comb begin
    free_sel = 1'b0;
    for (int k = 0; k < N_OUT; k++) begin
      if (sel_idx == chan_idx_t'(k)) free_sel = free[k];
    end
  end

  // Illegal selects are swallowed so a bad decode never wedges the CPU side.
  always_comb begin
    in_ready = 1'b1;
    if (bcast)       in_ready = &free;
    else if (sel_ok) in_ready = free_sel;
  end

  assign accept  = in_valid && in_ready;
  assign bad_set = accept && !bcast && !sel_ok;

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    assign push[k] = accept && (bcast || (sel_ok && sel_idx == chan_idx_t'(k)));

    dmux_stream_slot #(.D_WIDTH(D_WIDTH)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[k]),
      .din   (in_data),
      .ready (out_ready[k]),
      .valid (out_valid[k]),
      .dout  (out_data[k*D_WIDTH +: D_WIDTH])
    );
  end

  // A bad beat in the same cycle as a clear wins, so no event is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           bad_sel <= 1'b0;
    else if (bad_set)     bad_sel <= 1'b1;
    else if (bad_sel_clr) bad_sel <= 1'b0;
  end

endmodule
